// File: rtl/yacht_turn_ctrl.sv
// yacht_turn_ctrl: turn sequencing, category bookkeeping, scoring and winner selection for 1-4 player Yacht
module yacht_turn_ctrl #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_CAT      = 12,
    parameter int MAX_ROLLS    = 3,
    parameter int UPPER_CATS   = 6,
    parameter int BONUS_THRESH = 63,
    parameter int BONUS_PTS    = 35,
    parameter int SCORE_W      = 10,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int CW = $clog2(NUM_CAT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           btn_roll,
    input  logic                           btn_sel,
    input  logic                           btn_prev,
    input  logic                           btn_next,
    input  logic [4:0]                     hold_toggle,
    input  logic [7:0]                     calc_score,
    output logic [3:0]                     state,
    output logic [PW-1:0]                  player,
    output logic                           roll_trigger,
    output logic [2:0]                     roll_cnt,
    output logic [4:0]                     hold_mask,
    output logic [CW-1:0]                  category_idx,
    output logic [NUM_CAT-1:0]             cat_used,
    output logic [CW:0]                    round_num,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           game_over,
    output logic [PW-1:0]                  winner,
    output logic                           tie
);
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_TURN_START = 4'd1,
        S_WAIT       = 4'd2,
        S_ROLL       = 4'd3,
        S_SELECT     = 4'd4,
        S_COMMIT     = 4'd5,
        S_NEXT       = 4'd6,
        S_BONUS      = 4'd7,
        S_RESULT     = 4'd8,
        S_END        = 4'd9
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        player_q, player_d;
    logic [2:0]           roll_q, roll_d;
    logic [4:0]           hold_q, hold_d;
    logic [CW-1:0]        cat_q, cat_d;
    logic [CW:0]          round_q, round_d;
    logic [PW-1:0]        winner_q, winner_d;
    logic                 tie_q, tie_d;
    logic [NUM_CAT-1:0]   used_q [NUM_PLAYERS];
    logic [NUM_CAT-1:0]   used_d [NUM_PLAYERS];
    logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]   score_d [NUM_PLAYERS];
    logic [8:0]           upper_q [NUM_PLAYERS];
    logic [8:0]           upper_d [NUM_PLAYERS];

    logic [NUM_CAT-1:0]   cur_used;
    logic [CW-1:0]        first_free, up_free, down_free, iu, id;
    logic [SCORE_W-1:0]   best;
    logic [PW-1:0]        best_p;
    logic [2:0]           n_best;

    // Locate the lowest, next-higher and next-lower unused categories of the current player
    always_comb begin
        cur_used   = used_q[player_q];
        first_free = '0;
        up_free    = cat_q;
        down_free  = cat_q;
        iu         = cat_q;
        id         = cat_q;
        for (int i = NUM_CAT - 1; i >= 0; i--)
            if (!cur_used[i]) first_free = CW'(i);
        for (int k = NUM_CAT - 1; k >= 1; k--) begin
            iu = CW'((int'(cat_q) + k) % NUM_CAT);
            id = CW'((int'(cat_q) + NUM_CAT - k) % NUM_CAT);
            if (!cur_used[iu]) up_free = iu;
            if (!cur_used[id]) down_free = id;
        end
    end

    // Find the top score, the lowest player holding it, and how many players share it
    always_comb begin
        best   = score_q[0];
        best_p = '0;
        n_best = '0;
        for (int p = 1; p < NUM_PLAYERS; p++)
            if (score_q[p] > best) begin
                best   = score_q[p];
                best_p = PW'(p);
            end
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (score_q[p] == best) n_best = n_best + 3'd1;
    end

    // Next-state and datapath updates for every game phase
    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        roll_d   = roll_q;
        hold_d   = hold_q;
        cat_d    = cat_q;
        round_d  = round_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        used_d   = used_q;
        score_d  = score_q;
        upper_d  = upper_q;
        case (state_q)
            S_IDLE: state_d = S_TURN_START;
            S_TURN_START: begin
                roll_d  = '0;
                hold_d  = '0;
                cat_d   = first_free;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                hold_d = (roll_q != 3'd0) ? hold_q ^ hold_toggle : hold_q;
                if (btn_roll && int'(roll_q) < MAX_ROLLS)
                    state_d = S_ROLL;
                else if (btn_sel && roll_q != 3'd0)
                    state_d = S_SELECT;
            end
            S_ROLL: begin
                roll_d  = roll_q + 3'd1;
                state_d = (int'(roll_q) + 1 == MAX_ROLLS) ? S_SELECT : S_WAIT;
            end
            S_SELECT: begin
                cat_d   = btn_next ? up_free : btn_prev ? down_free : cat_q;
                state_d = btn_sel ? S_COMMIT : S_SELECT;
            end
            S_COMMIT: begin
                score_d[player_q]        = score_q[player_q] + SCORE_W'(calc_score);
                used_d[player_q][cat_q]  = 1'b1;
                if (int'(cat_q) < UPPER_CATS)
                    upper_d[player_q] = upper_q[player_q] + 9'(calc_score);
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (int'(player_q) < NUM_PLAYERS - 1) begin
                    player_d = player_q + PW'(1);
                    state_d  = S_TURN_START;
                end else if (int'(round_q) < NUM_CAT) begin
                    player_d = '0;
                    round_d  = round_q + (CW+1)'(1);
                    state_d  = S_TURN_START;
                end else begin
                    state_d = S_BONUS;
                end
            end
            S_BONUS: begin
                for (int p = 0; p < NUM_PLAYERS; p++)
                    if (int'(upper_q[p]) >= BONUS_THRESH)
                        score_d[p] = score_q[p] + SCORE_W'(BONUS_PTS);
                state_d = S_RESULT;
            end
            S_RESULT: begin
                winner_d = best_p;
                tie_d    = (n_best > 3'd1);
                state_d  = S_END;
            end
            S_END: state_d = S_END;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset to a fresh game
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            player_q <= '0;
            roll_q   <= '0;
            hold_q   <= '0;
            cat_q    <= '0;
            round_q  <= (CW+1)'(1);
            winner_q <= '0;
            tie_q    <= 1'b0;
            used_q   <= '{default: '0};
            score_q  <= '{default: '0};
            upper_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            roll_q   <= roll_d;
            hold_q   <= hold_d;
            cat_q    <= cat_d;
            round_q  <= round_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
            used_q   <= used_d;
            score_q  <= score_d;
            upper_q  <= upper_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_sc
        assign scores[p*SCORE_W +: SCORE_W] = score_q[p];
    end

    assign state        = state_q;
    assign player       = player_q;
    assign roll_trigger = (state_q == S_ROLL);
    assign roll_cnt     = roll_q;
    assign hold_mask    = hold_q;
    assign category_idx = cat_q;
    assign cat_used     = cur_used;
    assign round_num    = round_q;
    assign game_over    = (state_q == S_END);
    assign winner       = winner_q;
    assign tie          = tie_q;
endmodule

// File: tb/tb_yacht_turn_ctrl.sv
// tb_yacht_turn_ctrl: directed scenario bench for the three-player turn controller
module tb_yacht_turn_ctrl;
    localparam int NP = 3;
    localparam int SW = 10;

    logic clk = 1'b0, reset = 1'b0;
    logic btn_roll = 1'b0, btn_sel = 1'b0, btn_prev = 1'b0, btn_next = 1'b0;
    logic [4:0] hold_toggle = '0;
    logic [7:0] calc_score = '0;
    logic [3:0] state;
    logic [1:0] player;
    logic roll_trigger;
    logic [2:0] roll_cnt;
    logic [4:0] hold_mask;
    logic [3:0] category_idx;
    logic [11:0] cat_used;
    logic [4:0] round_num;
    logic [NP*SW-1:0] scores;
    logic game_over;
    logic [1:0] winner;
    logic tie;

    int errors = 0;
    int checks = 0;

    yacht_turn_ctrl #(.NUM_PLAYERS(NP)) dut (
        .clk(clk), .reset(reset), .btn_roll(btn_roll), .btn_sel(btn_sel),
        .btn_prev(btn_prev), .btn_next(btn_next), .hold_toggle(hold_toggle),
        .calc_score(calc_score), .state(state), .player(player),
        .roll_trigger(roll_trigger), .roll_cnt(roll_cnt), .hold_mask(hold_mask),
        .category_idx(category_idx), .cat_used(cat_used), .round_num(round_num),
        .scores(scores), .game_over(game_over), .winner(winner), .tie(tie)
    );

    always #5 clk = ~clk;

    function automatic int sc(input int p);
        return int'(scores[p*SW +: SW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_roll = 1'b0; btn_sel = 1'b0; btn_prev = 1'b0; btn_next = 1'b0;
        hold_toggle = '0; calc_score = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_next();
        btn_next = 1'b1; tick(); btn_next = 1'b0;
    endtask

    // From WAIT: one roll, enter SELECT, commit the highlighted category, land in WAIT (or RESULT at game end)
    task automatic take_turn(input logic [7:0] s);
        btn_roll = 1'b1; tick(); btn_roll = 1'b0;
        tick();
        btn_sel = 1'b1; tick(); btn_sel = 1'b0;
        calc_score = s;
        btn_sel = 1'b1; tick(); btn_sel = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic play_game(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
        int model [NP];
        int prev [NP];
        logic [7:0] s;
        for (int p = 0; p < NP; p++) begin model[p] = 0; prev[p] = 0; end
        for (int t = 0; t < 36; t++) begin
            s = (t % 3 == 0) ? s0 : (t % 3 == 1) ? s1 : s2;
            take_turn(s);
            model[t % 3] += int'(s);
            if (t < 35) begin
                checks++; if (sc(t % 3) !== model[t % 3]) begin errors++; $display("FAIL turn_score t=%0d: got %0d want %0d", t, sc(t % 3), model[t % 3]); end
                checks++; if (sc(t % 3) < prev[t % 3]) begin errors++; $display("FAIL score_wrap t=%0d: got %0d want >= %0d", t, sc(t % 3), prev[t % 3]); end
                prev[t % 3] = sc(t % 3);
            end
        end
        checks++; if (state !== 4'd8) begin errors++; $display("FAIL game_result_state: got %0d want 8", state); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (player !== 2'd0) begin errors++; $display("FAIL reset_player: got %0d want 0", player); end
        checks++; if (roll_cnt !== 3'd0) begin errors++; $display("FAIL reset_roll_cnt: got %0d want 0", roll_cnt); end
        checks++; if (hold_mask !== 5'd0) begin errors++; $display("FAIL reset_hold: got %b want 00000", hold_mask); end
        checks++; if (category_idx !== 4'd0) begin errors++; $display("FAIL reset_cat: got %0d want 0", category_idx); end
        checks++; if (cat_used !== 12'd0) begin errors++; $display("FAIL reset_cat_used: got %h want 000", cat_used); end
        checks++; if (round_num !== 5'd1) begin errors++; $display("FAIL reset_round: got %0d want 1", round_num); end
        checks++; if (scores !== '0) begin errors++; $display("FAIL reset_scores: got %h want 0", scores); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        checks++; if (winner !== 2'd0 || tie !== 1'b0) begin errors++; $display("FAIL reset_winner_tie: got %0d/%b want 0/0", winner, tie); end
        checks++; if (roll_trigger !== 1'b0) begin errors++; $display("FAIL reset_roll_trigger: got %b want 0", roll_trigger); end
        tick();
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL turn_start_state: got %0d want 1", state); end
        tick();
        checks++; if (state !== 4'd2) begin errors++; $display("FAIL wait_state: got %0d want 2", state); end
    endtask

    task automatic test_first_roll();
        btn_sel = 1'b1; hold_toggle = 5'b00101; tick(); btn_sel = 1'b0; hold_toggle = '0;
        checks++; if (state !== 4'd2) begin errors++; $display("FAIL early_sel_state: got %0d want 2", state); end
        checks++; if (hold_mask !== 5'b00000) begin errors++; $display("FAIL early_hold: got %b want 00000", hold_mask); end
        btn_roll = 1'b1; tick(); btn_roll = 1'b0;
        checks++; if (state !== 4'd3 || roll_trigger !== 1'b1) begin errors++; $display("FAIL roll_enter: got %0d/%b want 3/1", state, roll_trigger); end
        tick();
        checks++; if (state !== 4'd2 || roll_cnt !== 3'd1 || roll_trigger !== 1'b0) begin errors++; $display("FAIL roll_exit: got %0d/%0d/%b want 2/1/0", state, roll_cnt, roll_trigger); end
        hold_toggle = 5'b00101; tick(); hold_toggle = '0;
        checks++; if (hold_mask !== 5'b00101) begin errors++; $display("FAIL hold_set: got %b want 00101", hold_mask); end
        hold_toggle = 5'b00101; tick(); hold_toggle = '0;
        checks++; if (hold_mask !== 5'b00000) begin errors++; $display("FAIL hold_clear: got %b want 00000", hold_mask); end
    endtask

    task automatic test_roll_limit();
        int trig = 0;
        do_reset(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            btn_roll = 1'b1; tick(); btn_roll = 1'b0;
            trig += int'(roll_trigger);
            tick();
            trig += int'(roll_trigger);
        end
        checks++; if (trig !== 3) begin errors++; $display("FAIL roll_pulses: got %0d want 3", trig); end
        checks++; if (state !== 4'd4) begin errors++; $display("FAIL roll_limit_state: got %0d want 4", state); end
        checks++; if (roll_cnt !== 3'd3) begin errors++; $display("FAIL roll_limit_cnt: got %0d want 3", roll_cnt); end
        hold_toggle = 5'b11111; tick(); hold_toggle = '0;
        checks++; if (hold_mask !== 5'b00000) begin errors++; $display("FAIL select_hold_ignored: got %b want 00000", hold_mask); end
    endtask

    task automatic test_used_skip();
        do_reset(); tick(); tick();
        take_turn(8'd7);
        checks++; if (player !== 2'd1) begin errors++; $display("FAIL handover_player: got %0d want 1", player); end
        checks++; if (sc(0) !== 7) begin errors++; $display("FAIL p0_score: got %0d want 7", sc(0)); end
        checks++; if (cat_used !== 12'h000 || category_idx !== 4'd0) begin errors++; $display("FAIL p1_fresh: got %h/%0d want 000/0", cat_used, category_idx); end
        take_turn(8'd5);
        take_turn(8'd6);
        checks++; if (sc(1) !== 5 || sc(2) !== 6) begin errors++; $display("FAIL p1_p2_scores: got %0d/%0d want 5/6", sc(1), sc(2)); end
        checks++; if (round_num !== 5'd2 || player !== 2'd0) begin errors++; $display("FAIL round2: got r%0d p%0d want r2 p0", round_num, player); end
        checks++; if (cat_used !== 12'h001) begin errors++; $display("FAIL round2_used: got %h want 001", cat_used); end
        checks++; if (category_idx !== 4'd1) begin errors++; $display("FAIL round2_first_free: got %0d want 1", category_idx); end
        btn_roll = 1'b1; tick(); btn_roll = 1'b0; tick();
        btn_sel = 1'b1; tick(); btn_sel = 1'b0;
        btn_prev = 1'b1; tick(); btn_prev = 1'b0;
        checks++; if (category_idx !== 4'd11) begin errors++; $display("FAIL prev_wrap: got %0d want 11", category_idx); end
        pulse_next();
        checks++; if (category_idx !== 4'd1) begin errors++; $display("FAIL next_wrap_skip: got %0d want 1", category_idx); end
        pulse_next(); pulse_next(); pulse_next();
        checks++; if (category_idx !== 4'd4) begin errors++; $display("FAIL next_steps: got %0d want 4", category_idx); end
        btn_next = 1'b1; btn_prev = 1'b1; tick(); btn_next = 1'b0; btn_prev = 1'b0;
        checks++; if (category_idx !== 4'd5) begin errors++; $display("FAIL next_prev_collision: got %0d want 5", category_idx); end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1; btn_next = 1'b1; btn_sel = 1'b1; tick(); reset = 1'b0; btn_next = 1'b0; btn_sel = 1'b0;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL midreset_state: got %0d want 0", state); end
        checks++; if (scores !== '0) begin errors++; $display("FAIL midreset_scores: got %h want 0", scores); end
        checks++; if (cat_used !== 12'h000 || round_num !== 5'd1) begin errors++; $display("FAIL midreset_used_round: got %h/%0d want 000/1", cat_used, round_num); end
        checks++; if (category_idx !== 4'd0 || player !== 2'd0) begin errors++; $display("FAIL midreset_cat_player: got %0d/%0d want 0/0", category_idx, player); end
    endtask

    task automatic test_full_game();
        do_reset(); tick(); tick();
        play_game(8'd11, 8'd11, 8'd11);
        tick();
        checks++; if (state !== 4'd9 || game_over !== 1'b1) begin errors++; $display("FAIL tie_game_end: got %0d/%b want 9/1", state, game_over); end
        for (int p = 0; p < NP; p++) begin
            checks++; if (sc(p) !== 167) begin errors++; $display("FAIL tie_final_score p%0d: got %0d want 167", p, sc(p)); end
        end
        checks++; if (tie !== 1'b1 || winner !== 2'd0) begin errors++; $display("FAIL tie_result: got tie=%b win=%0d want tie=1 win=0", tie, winner); end
        checks++; if (round_num !== 5'd12) begin errors++; $display("FAIL final_round: got %0d want 12", round_num); end
        checks++; if (cat_used !== 12'hFFF) begin errors++; $display("FAIL final_used: got %h want fff", cat_used); end
    endtask

    task automatic test_end_hold();
        btn_roll = 1'b1; btn_sel = 1'b1; btn_next = 1'b1; hold_toggle = 5'b11111; calc_score = 8'd50;
        tick(); tick(); tick();
        btn_roll = 1'b0; btn_sel = 1'b0; btn_next = 1'b0; hold_toggle = '0;
        checks++; if (state !== 4'd9 || game_over !== 1'b1) begin errors++; $display("FAIL end_hold_state: got %0d/%b want 9/1", state, game_over); end
        checks++; if (sc(0) !== 167 || sc(2) !== 167) begin errors++; $display("FAIL end_hold_scores: got %0d/%0d want 167/167", sc(0), sc(2)); end
        checks++; if (hold_mask !== 5'd0 || roll_trigger !== 1'b0) begin errors++; $display("FAIL end_hold_dice: got %b/%b want 00000/0", hold_mask, roll_trigger); end
    endtask

    task automatic test_winner();
        do_reset(); tick(); tick();
        play_game(8'd10, 8'd12, 8'd11);
        tick();
        checks++; if (sc(0) !== 120) begin errors++; $display("FAIL below_thresh_no_bonus: got %0d want 120", sc(0)); end
        checks++; if (sc(1) !== 179) begin errors++; $display("FAIL p1_bonus: got %0d want 179", sc(1)); end
        checks++; if (sc(2) !== 167) begin errors++; $display("FAIL p2_bonus: got %0d want 167", sc(2)); end
        checks++; if (winner !== 2'd1 || tie !== 1'b0) begin errors++; $display("FAIL unique_winner: got win=%0d tie=%b want win=1 tie=0", winner, tie); end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL winner_game_over: got %b want 1", game_over); end
    endtask

    initial begin
        test_reset();
        test_first_roll();
        test_roll_limit();
        test_used_skip();
        test_mid_reset();
        test_full_game();
        test_end_hold();
        test_winner();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/yacht_turn_ctrl.md
# yacht_turn_ctrl

Parametrised turn and score controller for the Yacht dice game, the successor to the fixed two-player game FSM. It sits between the debounced button block, the dice/roll block and the category score calculator. It supports 1–4 players and dice hold masks. It tracks used categories per player, so a category cannot be scored twice. At game end it settles the upper bonus and computes the winner.

## Interface
Parameters:
- NUM_PLAYERS, 2: player count, 1..4; PW = max(1, clog2(NUM_PLAYERS)).
- NUM_CAT, 12: categories per player; also the round count; CW = clog2(NUM_CAT).
- MAX_ROLLS, 3: rolls allowed per turn, 1..7.
- UPPER_CATS, 6: categories 0..UPPER_CATS-1 count toward the upper bonus.
- BONUS_THRESH, 63: upper-sum threshold for the bonus.
- BONUS_PTS, 35: bonus added when the threshold is reached.
- SCORE_W, 10: width of each player's score.

Ports (all buttons are single-cycle pulses from the debouncer):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_roll  in  1  roll request.
- btn_sel  in  1  enter selection / confirm category.
- btn_prev  in  1  previous unused category.
- btn_next  in  1  next unused category.
- hold_toggle  in  5  per-die hold toggle pulses.
- calc_score  in  8  score of category_idx for the current dice.
- state  out  4  FSM state code.
- player  out  PW  current player, 0-based.
- roll_trigger  out  1  combinational; high while state==ROLL.
- roll_cnt  out  3  rolls taken this turn.
- hold_mask  out  5  dice held; the dice block must not change held dice.
- category_idx  out  CW  highlighted category.
- cat_used  out  NUM_CAT  used mask of the current player.
- round_num  out  CW+1  round, 1..NUM_CAT.
- scores  out  NUM_PLAYERS*SCORE_W  player p at bits [p*SCORE_W +: SCORE_W].
- game_over  out  1  high in END.
- winner  out  PW  winning player, valid while game_over.
- tie  out  1  two or more players share the top score.

## Operation
State codes: IDLE 0, TURN_START 1, WAIT 2, ROLL 3, SELECT 4, COMMIT 5, NEXT 6, BONUS 7, RESULT 8, END 9.

- IDLE → TURN_START unconditionally.
- TURN_START:
  - roll_cnt←0, hold_mask←0.
  - category_idx← lowest unused category of the current player.
  - → WAIT.
- WAIT:
  - btn_roll with roll_cnt<MAX_ROLLS → ROLL.
  - Otherwise, btn_sel with roll_cnt>0 → SELECT. btn_sel with roll_cnt==0 is ignored.
  - If roll_cnt>0: hold_mask ^= hold_toggle. Toggles are ignored before the first roll.
- ROLL (one cycle):
  - roll_cnt+1.
  - → SELECT if the new count equals MAX_ROLLS, else → WAIT.
- SELECT:
  - btn_next moves to the next unused index upward, wrapping NUM_CAT-1→0.
  - btn_prev moves to the next unused index downward, wrapping 0→NUM_CAT-1.
  - If both are pulsed in the same cycle, next wins.
  - If no other category is unused, category_idx stays.
  - btn_sel → COMMIT.
  - btn_roll and hold_toggle are ignored.
- COMMIT (one cycle):
  - scores[player] += calc_score (calc_score sampled this cycle).
  - used[player][category_idx]←1.
  - If category_idx<UPPER_CATS: upper[player] += calc_score (9-bit accumulator).
  - → NEXT.
- NEXT:
  - If player<NUM_PLAYERS-1: player+1, → TURN_START.
  - Else if round_num<NUM_CAT: player←0, round_num+1, → TURN_START.
  - Else → BONUS.
- BONUS (one cycle): for each player with upper ≥ BONUS_THRESH, add BONUS_PTS to that player's score. → RESULT.
- RESULT (one cycle):
  - winner← lowest index holding the maximum score.
  - tie←1 if two or more players hold the maximum.
  - → END.
- END: game_over=1. All state is held until reset; all buttons are ignored.

Arithmetic:
- Scores use unsigned adds. Overflow is impossible with the default parameters.
- The verification bench must flag any wrap of a score.

## Timing
- Reset values (one cycle after reset is sampled): state=IDLE, player=0, roll_cnt=0, hold_mask=0, category_idx=0, cat_used=0, round_num=1, all scores and upper sums=0, game_over=0, winner=0, tie=0, roll_trigger=0.
- Reset asserted in any state, including mid-turn, overrides all inputs the same cycle.
- Every button is acted on in the cycle it is high; the state changes on the next edge.
- roll_trigger is high for exactly one cycle per accepted roll.
- From btn_sel in SELECT, the score is visible on `scores` 2 cycles later.
- Turn handover: btn_sel in SELECT → COMMIT → NEXT → TURN_START → WAIT. The next player is able to roll 4 cycles after btn_sel.
- Final commit to game_over: 4 cycles (NEXT, BONUS, RESULT, END).

## Test plan
- Roll limit: with MAX_ROLLS=3, pulse btn_roll four times in WAIT → exactly 3 roll_trigger pulses, state=SELECT after the third, and the fourth pulse is ignored.
- First-roll rule: btn_sel and hold_toggle=5'b00101 before any roll → state stays WAIT and hold_mask=0. After one roll, hold_toggle=5'b00101 twice → hold_mask 5'b00101, then 0.
- Used-category skip: player 0 commits category 0 in round 1. In round 2, TURN_START gives category_idx=1, and btn_prev wraps to 11 (skipping 0).
- Full game, NUM_PLAYERS=3, calc_score=11 on every commit:
  - upper sum 66 → bonus applied.
  - All scores equal 167.
  - tie=1, winner=0, game_over=1, round_num=12.
- Next/prev collision: btn_next and btn_prev in the same SELECT cycle at category_idx=4 (5 unused) → category_idx=5.
- Mid-turn reset: assert reset in SELECT with scores nonzero → next cycle state=0, all scores 0, cat_used=0, round_num=1.
